trng_byte_collector: RTL and testbench

//  Consumer side of the ring-oscillator entropy bit: synchronises the free-running raw bit,

---
 rtl/trng_pkg.sv | 9 +
 rtl/trng_sync.sv | 26 ++
 rtl/trng_byte_collector.sv | 145 ++++++++++++++
 tb/tb_trng_byte_collector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared defaults and pair-FSM state type for the TRNG byte collector
package trng_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic {EMPTY, HALF} vn_state_t;

endpackage

// File: rtl/trng_sync.sv
// trng_sync: flop chain bringing an asynchronous bit into the clk domain
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d_i    in   asynchronous input bit
//   q_o    out  synchronised bit, STAGES clocks behind d_i
module trng_sync
    import trng_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trng_byte_collector.sv
// trng_byte_collector: samples the ring-oscillator bit, optionally von Neumann debiases it,
// packs accepted bits MSB-first into WIDTH-bit words and offers them on a valid/ready stream.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   ena          in   collector enable; low freezes sampling
//   raw_bit      in   asynchronous entropy bit
//   vn_en        in   1 = von Neumann debias, 0 = pass samples through
//   data         out  packed random word
//   valid        out  data holds an unconsumed word
//   ready        in   consumer accepts data when valid && ready
//   health_fail  out  sticky repetition-count failure
// Build option: define TRNG_HEALTH_EN to include the repetition-count health test;
// otherwise health_fail is tied low and RCT_CUTOFF is unused.
module trng_byte_collector
    import trng_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SAMPLE_DIV  = 4,
    parameter int RCT_CUTOFF  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             raw_bit,
    input  logic             vn_en,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             health_fail
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BW = $clog2(WIDTH);

    logic             samp;
    logic [CW-1:0]    cnt_q, cnt_d;
    vn_state_t        vn_q, vn_d;
    logic             first_q, first_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] data_q, data_d, word;
    logic             valid_q, valid_d;
    logic             tick, acc, abit, at_last, take, load, fail_now;

    trng_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (raw_bit),
        .q_o   (samp)
    );

    always_comb begin
        tick    = ena && (cnt_q == CW'(SAMPLE_DIV - 1));
        cnt_d   = !ena ? cnt_q : (tick ? '0 : cnt_q + CW'(1));
        acc     = 1'b0;
        abit    = samp;
        vn_d    = vn_q;
        first_d = first_q;
        // vn_en low parks the pair FSM in EMPTY, so toggling vn_en always restarts pairing
        if (!vn_en) begin
            vn_d = EMPTY;
            acc  = tick;
        end else if (tick) begin
            if (vn_q == EMPTY) begin
                vn_d    = HALF;
                first_d = samp;
            end else begin
                vn_d = EMPTY;
                acc  = first_q != samp;
                abit = first_q;
            end
        end
        at_last = bcnt_q == BW'(WIDTH - 1);
        // the completing bit is dropped while the previous word is still unconsumed
        take    = acc && !fail_now && !(at_last && valid_q && !ready);
        load    = take && at_last;
        word    = {shreg_q, abit};
        shreg_d = fail_now ? '0 : (take ? word[WIDTH-2:0] : shreg_q);
        bcnt_d  = (fail_now || load) ? '0 : (take ? bcnt_q + BW'(1) : bcnt_q);
        data_d  = load ? word : data_q;
        valid_d = load || (valid_q && !ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            vn_q    <= EMPTY;
            first_q <= 1'b0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            vn_q    <= vn_d;
            first_q <= first_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    logic [RW-1:0] rct_q, rct_d;
    logic          last_q, fail_q;

    // run length of identical raw samples; zero means no sample seen yet
    always_comb begin
        rct_d = rct_q;
        if (tick)
            rct_d = (rct_q == '0 || samp != last_q) ? RW'(1) :
                    (rct_q == RW'(RCT_CUTOFF)) ? rct_q : rct_q + RW'(1);
    end

    // failure acts on the same edge the cutoff is reached, so that sample cannot complete a word
    assign fail_now = fail_q || (rct_d == RW'(RCT_CUTOFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rct_q  <= '0;
            last_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            rct_q  <= rct_d;
            last_q <= tick ? samp : last_q;
            fail_q <= fail_now;
        end
    end

    assign health_fail = fail_q;
`else
    logic unused_rct_cutoff;
    assign unused_rct_cutoff = ^RCT_CUTOFF;
    assign fail_now          = 1'b0;
    assign health_fail       = 1'b0;
`endif

endmodule

// File: tb/tb_trng_byte_collector.sv
// tb_trng_byte_collector: scoreboard bench for trng_byte_collector (SAMPLE_DIV=1, WIDTH=8)
module tb_trng_byte_collector;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0, raw_bit = 1'b0, vn_en = 1'b0, ready = 1'b0;
    logic [7:0] data;
    logic       valid, health_fail;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    logic       stim[$];
    logic       pre_v;

    trng_byte_collector #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .SAMPLE_DIV  (1),
        .RCT_CUTOFF  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .raw_bit     (raw_bit),
        .vn_en       (vn_en),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every completed transfer must match the oldest expected word
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            check("sb_pending", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) check("sb_word", 32'(data), 32'(exp_q.pop_front()));
        end
    end

    task automatic set_stim(input logic [31:0] v, input int n);
        stim = {};
        for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    function automatic logic [7:0] word_at(input int i);
        logic [7:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[6:0], stim[i + j]};
        return w;
    endfunction

    task automatic do_reset(input logic vn);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        ena     = 1'b0;
        ready   = 1'b1;
        vn_en   = vn;
        raw_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // stim[i] reaches the sampled bit two clocks after it is driven, so ena trails by two
    task automatic feed(input int rdy_at);
        int n;
        n = stim.size();
        for (int k = 0; k < n + 2; k++) begin
            @(posedge clk);
            #1;
            raw_bit = stim[(k < n) ? k : n - 1];
            ena     = (k >= 2);
            if (k == rdy_at) ready = 1'b1;
        end
        @(negedge clk) pre_v = valid;
        @(posedge clk);
        #1 ena = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] w, wa, wb;
        int nb;
        #12;
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_hf", 32'(health_fail), 0);

        // pass-through packing and one-clock latency
        do_reset(1'b0);
        set_stim(32'hB2, 8);
        exp_q.push_back(8'hB2);
        feed(-1);
        check("lat_pre", 32'(pre_v), 0);
        check("lat_valid", 32'(valid), 1);
        @(negedge clk);
        check("valid_drop", 32'(valid), 0);
        drain();

        // von Neumann: first bit of each differing pair, 00/11 discarded
        do_reset(1'b1);
        set_stim(32'h636996, 24);
        w  = '0;
        nb = 0;
        for (int i = 0; i < 24; i += 2)
            if (stim[i] != stim[i + 1]) begin
                w = {w[6:0], stim[i]};
                nb++;
                if (nb % 8 == 0) exp_q.push_back(w);
            end
        feed(-1);
        drain();

        // backpressure: word held, seven bits kept, the rest dropped
        do_reset(1'b0);
        ready = 1'b0;
        set_stim(32'hC35A96, 24);
        wa = word_at(0);
        wb = word_at(8);
        exp_q.push_back(wa);
        feed(-1);
        check("bp_valid", 32'(valid), 1);
        check("bp_data", 32'(data), 32'(wa));
        repeat (4) @(negedge clk);
        check("bp_stable", 32'(data), 32'(wa));
        @(posedge clk);
        #1 ready = 1'b1;
        set_stim(32'h81, 8);
        exp_q.push_back({wb[7:1], stim[0]});
        feed(-1);
        drain();

        // ready rises in the cycle the next word completes: valid stays high
        do_reset(1'b0);
        ready = 1'b0;
        set_stim(32'hA53C, 16);
        exp_q.push_back(word_at(0));
        exp_q.push_back(word_at(8));
        feed(17);
        check("b2b_pre", 32'(pre_v), 1);
        check("b2b_valid", 32'(valid), 1);
        drain();

        // stuck-at-one source
        do_reset(1'b0);
        stim = {};
        repeat (40) stim.push_back(1'b1);
`ifdef TRNG_HEALTH_EN
        repeat (3) exp_q.push_back(8'hFF);
        feed(-1);
        check("hf_set", 32'(health_fail), 1);
        check("hf_no_valid", 32'(valid), 0);
`else
        repeat (5) exp_q.push_back(8'hFF);
        feed(-1);
        check("hf_off", 32'(health_fail), 0);
`endif
        drain();

        // asynchronous reset with a pending word and a partial word
        do_reset(1'b0);
        ready = 1'b0;
        set_stim(32'hF0F, 12);
        feed(-1);
        check("ar_pre_valid", 32'(valid), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_data", 32'(data), 0);
        check("ar_valid", 32'(valid), 0);
        check("ar_hf", 32'(health_fail), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        set_stim(32'h69, 8);
        exp_q.push_back(word_at(0));
        feed(-1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, limit 200000", $time);
        $fatal(1);
    end

endmodule
